// File: rtl/vga_rect_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : vga_rect_if                                                      |
// | Purpose : Command and pixel-write bundle for vga_rect_engine.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface vga_rect_if #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3
);
    logic                start;
    logic [1:0]          mode;
    logic [X_W-1:0]      x0;
    logic [Y_W-1:0]      y0;
    logic [X_W-1:0]      w;
    logic [Y_W-1:0]      h;
    logic [COLOUR_W-1:0] colour_in;
    logic                hold;
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
    logic                plot;
    logic                busy;
    logic                done;

    modport master (
        output start, mode, x0, y0, w, h, colour_in, hold,
        input  x, y, colour, plot, busy, done
    );

    modport slave (
        input  start, mode, x0, y0, w, h, colour_in, hold,
        output x, y, colour, plot, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/vga_rect_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : vga_rect_engine                                                  |
// | Purpose : Raster-scans fill/outline/clear commands into clipped pixels.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vga_rect_engine #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic       clock,
    input  logic       reset,
    vga_rect_if.slave  bus
);
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_DRAW = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [1:0] c_MODE_OUTLINE = 2'd1;
    localparam logic [1:0] c_MODE_CLEAR   = 2'd2;

    localparam logic [X_W-1:0] c_CLEAR_W = X_W'(SCREEN_W);
    localparam logic [Y_W-1:0] c_CLEAR_H = Y_W'(SCREEN_H);
    localparam logic [X_W:0]   c_LIM_X   = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0]   c_LIM_Y   = (Y_W+1)'(SCREEN_H);

    logic [1:0]          r_state,   w_state_n;
    logic                r_outline, w_outline_n;
    logic [X_W-1:0]      r_x0,      w_x0_n;
    logic [Y_W-1:0]      r_y0,      w_y0_n;
    logic [X_W-1:0]      r_w,       w_w_n;
    logic [Y_W-1:0]      r_h,       w_h_n;
    logic [COLOUR_W-1:0] r_col_lat, w_col_n;
    logic [X_W-1:0]      r_cx,      w_cx_n;
    logic [Y_W-1:0]      r_cy,      w_cy_n;

    logic [X_W-1:0]      r_x;
    logic [Y_W-1:0]      r_y;
    logic [COLOUR_W-1:0] r_colour;
    logic                r_plot;

    logic                w_present;
    logic [X_W:0]        w_px;
    logic [Y_W:0]        w_py;
    logic                w_on_border;
    logic                w_plot_n;

    // Counters always hold the most recently presented position; a new
    // position is presented on every non-held DRAW edge and on the start edge.
    always_comb begin
        w_state_n   = r_state;
        w_outline_n = r_outline;
        w_x0_n      = r_x0;
        w_y0_n      = r_y0;
        w_w_n       = r_w;
        w_h_n       = r_h;
        w_col_n     = r_col_lat;
        w_cx_n      = r_cx;
        w_cy_n      = r_cy;
        w_present   = 1'b0;

        case (r_state)
            c_DRAW: begin
                if (!bus.hold) begin
                    if ((r_cx == r_w - X_W'(1)) && (r_cy == r_h - Y_W'(1))) begin
                        w_state_n = c_DONE;
                    end else begin
                        w_present = 1'b1;
                        if (r_cx == r_w - X_W'(1)) begin
                            w_cx_n = '0;
                            w_cy_n = r_cy + Y_W'(1);
                        end else begin
                            w_cx_n = r_cx + X_W'(1);
                        end
                    end
                end
            end
            default: begin
                w_state_n = c_IDLE;
                if (bus.start) begin
                    w_outline_n = (bus.mode == c_MODE_OUTLINE);
                    w_col_n     = bus.colour_in;
                    w_cx_n      = '0;
                    w_cy_n      = '0;
                    if (bus.mode == c_MODE_CLEAR) begin
                        w_x0_n = '0;
                        w_y0_n = '0;
                        w_w_n  = c_CLEAR_W;
                        w_h_n  = c_CLEAR_H;
                    end else begin
                        w_x0_n = bus.x0;
                        w_y0_n = bus.y0;
                        w_w_n  = bus.w;
                        w_h_n  = bus.h;
                    end
                    if ((w_w_n == '0) || (w_h_n == '0)) begin
                        w_state_n = c_DONE;
                    end else begin
                        w_state_n = c_DRAW;
                        w_present = 1'b1;
                    end
                end
            end
        endcase

        // One extra bit keeps right/bottom overflow from wrapping back on screen.
        w_px        = {1'b0, w_x0_n} + {1'b0, w_cx_n};
        w_py        = {1'b0, w_y0_n} + {1'b0, w_cy_n};
        w_on_border = (w_cx_n == '0) || (w_cx_n == w_w_n - X_W'(1)) ||
                      (w_cy_n == '0) || (w_cy_n == w_h_n - Y_W'(1));
        w_plot_n    = w_present && (w_px < c_LIM_X) && (w_py < c_LIM_Y) &&
                      (!w_outline_n || w_on_border);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_outline <= 1'b0;
            r_x0      <= '0;
            r_y0      <= '0;
            r_w       <= '0;
            r_h       <= '0;
            r_col_lat <= '0;
            r_cx      <= '0;
            r_cy      <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_colour  <= '0;
            r_plot    <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_outline <= w_outline_n;
            r_x0      <= w_x0_n;
            r_y0      <= w_y0_n;
            r_w       <= w_w_n;
            r_h       <= w_h_n;
            r_col_lat <= w_col_n;
            r_cx      <= w_cx_n;
            r_cy      <= w_cy_n;
            r_plot    <= w_plot_n;
            if (w_present) begin
                r_x      <= w_px[X_W-1:0];
                r_y      <= w_py[Y_W-1:0];
                r_colour <= w_col_n;
            end
        end
    end

    assign bus.x      = r_x;
    assign bus.y      = r_y;
    assign bus.colour = r_colour;
    assign bus.plot   = r_plot;
    assign bus.busy   = (r_state == c_DRAW);
    assign bus.done   = (r_state == c_DONE);
endmodule
`default_nettype wire

// File: tb/tb_vga_rect_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_vga_rect_engine                                               |
// | Purpose : Directed and randomized commands against a raster-list model.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_vga_rect_engine;
    localparam int c_SW = 160;
    localparam int c_SH = 120;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    vga_rect_if #(.X_W(8), .Y_W(7), .COLOUR_W(3)) bus ();

    vga_rect_engine #(
        .X_W(8), .Y_W(7), .COLOUR_W(3), .SCREEN_W(c_SW), .SCREEN_H(c_SH)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Expected scan positions in raster order: plot flag and pixel address.
    bit e_plot[$];
    int e_x[$];
    int e_y[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic [1:0] m, input int x0, input int y0,
                           input int w, input int h, input logic [2:0] col,
                           input int hold_pct, input logic [31:0] hold_force,
                           input int start_cyc, input bit check_idle);
        int ex0, ey0, ew, eh, n, holds, p, sc;
        bit outline, held, exp_busy, exp_done, finished;
        logic [7:0] tx;
        logic [6:0] ty;

        ex0 = (m == 2'd2) ? 0    : x0;
        ey0 = (m == 2'd2) ? 0    : y0;
        ew  = (m == 2'd2) ? c_SW : w;
        eh  = (m == 2'd2) ? c_SH : h;
        outline = (m == 2'd1);
        e_plot.delete(); e_x.delete(); e_y.delete();
        for (int cy = 0; cy < eh; cy++) begin
            for (int cx = 0; cx < ew; cx++) begin
                e_plot.push_back((ex0 + cx < c_SW) && (ey0 + cy < c_SH) &&
                    (!outline || cx == 0 || cx == ew - 1 || cy == 0 || cy == eh - 1));
                e_x.push_back(ex0 + cx);
                e_y.push_back(ey0 + cy);
            end
        end
        n  = ew * eh;
        sc = (start_cyc < 0) ? ((n > 0) ? int'($urandom_range(n, 1)) : 0) : start_cyc;

        bus.start = 1'b1; bus.mode = m; bus.x0 = 8'(x0); bus.y0 = 7'(y0);
        bus.w = 8'(w); bus.h = 7'(h); bus.colour_in = col; bus.hold = 1'b0;
        @(posedge clk);

        holds = 0; p = 0; held = 1'b0; finished = 1'b0;
        for (int k = 1; k <= 30000; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            exp_busy = (k <= n + holds);
            exp_done = (k == n + holds + 1);
            chk("busy", 32'(bus.busy), 32'(exp_busy));
            chk("done", 32'(bus.done), 32'(exp_done));
            if (exp_busy && held) begin
                chk("stall_plot", 32'(bus.plot), 32'd0);
            end else if (exp_busy) begin
                chk("plot", 32'(bus.plot), 32'(e_plot[p]));
                if (e_plot[p]) begin
                    tx = 8'(e_x[p]);
                    ty = 7'(e_y[p]);
                    chk("pixel", 32'({bus.x, bus.y, bus.colour}), 32'({tx, ty, col}));
                end
                p++;
            end else begin
                chk("plot_off", 32'(bus.plot), 32'd0);
            end
            if (exp_done) begin
                finished = 1'b1;
                break;
            end
            held = exp_busy && (((k < 32) && hold_force[k]) ||
                                ($urandom_range(99) < hold_pct));
            if (held) holds++;
            bus.hold = held;
            if (k == sc) begin
                bus.start = 1'b1; bus.mode = 2'($urandom); bus.x0 = 8'($urandom);
                bus.y0 = 7'($urandom); bus.w = 8'($urandom); bus.h = 7'($urandom);
                bus.colour_in = 3'($urandom);
            end
        end
        bus.hold = 1'b0;
        chk("finished", 32'(finished), 32'd1);
        chk("positions", 32'(p), 32'(n));
        if (check_idle) begin
            @(negedge clk);
            chk("idle", 32'({bus.busy, bus.done, bus.plot}), 32'd0);
        end
    endtask

    initial begin
        logic [1:0] m;
        rst = 1'b1;
        bus.start = 1'b0; bus.mode = '0; bus.x0 = '0; bus.y0 = '0;
        bus.w = '0; bus.h = '0; bus.colour_in = '0; bus.hold = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", 32'({bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.done}), 32'd0);
        rst = 1'b0;

        run_cmd(2'd0,  10,  12, 3, 2, 3'b101, 0, 32'd0,     0, 1'b1);
        run_cmd(2'd1,  20,  30, 4, 3, 3'b011, 0, 32'd0,     0, 1'b1);
        run_cmd(2'd0, 158, 118, 4, 4, 3'b010, 0, 32'd0,     0, 1'b1);
        run_cmd(2'd0,   5,   5, 0, 5, 3'b001, 0, 32'd0,     0, 1'b1);
        run_cmd(2'd0,  40,  50, 3, 1, 3'b101, 0, 32'b110,   4, 1'b1);
        run_cmd(2'd3,  70,  60, 2, 2, 3'b110, 0, 32'd0,     0, 1'b0);
        run_cmd(2'd1, 155, 100, 9, 4, 3'b111, 0, 32'd0,     0, 1'b1);

        for (int i = 0; i < 25; i++) begin
            m = 2'($urandom_range(2));
            if (m == 2'd2) m = 2'd3;
            if (i % 5 == 0) m = 2'd1;
            run_cmd(m, int'($urandom_range(255)), int'($urandom_range(127)),
                    int'($urandom_range(10)), int'($urandom_range(6)),
                    3'($urandom), 30, 32'd0, -1, 1'($urandom));
        end

        run_cmd(2'd2, 77, 9, 3, 3, 3'b000, 0, 32'd0, 0, 1'b1);

        bus.start = 1'b1; bus.mode = 2'd2; bus.colour_in = 3'b100;
        @(posedge clk);
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (k == 50) rst = 1'b1;
        end
        @(negedge clk);
        chk("midreset_outs", 32'({bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.done}), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("post_reset_idle", 32'({bus.plot, bus.busy, bus.done}), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
